fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Decoupling instruction buffer between the 2-wide instruction fetch ROM and decode.
- Accepts up to two {address, instruction} pairs per cycle from fetch, qualified by the fetch valid[1:0] vector.
- Presents up to two oldest entries per cycle to decode, in program order.
- Supports a branch-mispredict flush.

Parameters:
ADDR_WIDTH, 32, width of instruction address
DATA_WIDTH, 32, width of instruction word
DEPTH, 8, number of entries; power of two, >= 4

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  discard all entries (mispredict/redirect)
enq_valid  input  2  per-slot valid from fetch; bit0 = older slot
enq_addr_0  input  ADDR_WIDTH  address of slot 0
enq_addr_1  input  ADDR_WIDTH  address of slot 1
enq_inst_0  input  DATA_WIDTH  instruction of slot 0
enq_inst_1  input  DATA_WIDTH  instruction of slot 1
enq_ready  output  1  queue can take two entries this cycle; fetch holds PC when low
deq_ready  input  1  decode consumes every presented valid entry this cycle
deq_valid  output  2  bit0 = head valid, bit1 = head+1 valid
deq_addr_0  output  ADDR_WIDTH  head address
deq_addr_1  output  ADDR_WIDTH  head+1 address
deq_inst_0  output  DATA_WIDTH  head instruction
deq_inst_1  output  DATA_WIDTH  head+1 instruction
count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Clocking and reset:
  - Single clock domain; reset synchronous active-high.
  - Reset: head=0, tail=0, count=0, deq_valid=2'b00, enq_ready=1.
  - Reset has priority over flush, enqueue and dequeue.
- Storage: circular buffer of DEPTH {addr, inst} entries.
  - head/tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- enq_ready = (DEPTH - count) >= 2.
  - Combinational from registered count only; does not credit same-cycle dequeue.
- Enqueue fires when enq_ready=1 and enq_valid != 0.
  - Valid slots are written compacted in order (slot 0 first) at tail, tail+1.
  - n_enq = popcount(enq_valid).
  - enq_valid=2'b10 writes slot 1 alone at tail.
  - When enq_ready=0, enq_valid is ignored and no state changes from the enqueue side.
- Dequeue outputs:
  - deq_valid[0] = count>=1; deq_valid[1] = count>=2.
  - Read combinationally from storage at head and head+1 (mod DEPTH).
  - Data outputs are forced to 0 when the corresponding deq_valid bit is 0.
- Dequeue fires when deq_ready=1: n_deq = popcount(deq_valid); head advances by n_deq.
- Latency: an entry written at edge N appears on deq outputs in cycle N+1. No enqueue-to-dequeue bypass.
- Simultaneous enqueue and dequeue: count_next = count + n_enq - n_deq.
  - Both pointers update independently in the same edge.
- Full (count==DEPTH): enq_ready=0, deq_valid=2'b11.
- count==DEPTH-1: enq_ready=0, even if a dequeue occurs that cycle.
- Empty: deq_valid=2'b00; deq_ready is ignored.
- Flush:
  - At an edge with flush=1 (rst=0): head=tail=count=0.
  - Any same-cycle enqueue or dequeue is discarded.
  - In the following cycle deq_valid=2'b00 and enq_ready=1.
- No FSM beyond the pointer/count state. count never exceeds DEPTH nor underflows; the verifier asserts this invariant.
- Order is preserved: the dequeue sequence equals the enqueue sequence with flushed entries removed.

Test Plan:
- Reset then idle: rst=1 one cycle -> count=0, deq_valid=00, enq_ready=1; all deq data 0.
- Two-wide fill:
  - Stimulus: deq_ready=0; enq_valid=11 each cycle with addrs 0x0/0x4, 0x8/0xC, ...
  - Required: count 2,4,6,8; enq_ready drops to 0 once count=8 (DEPTH=8).
  - Required: a further enqueue at count=8 is ignored; deq_addr_0=0x0, deq_addr_1=0x4.
- Predict-taken and compaction:
  - Stimulus: enq_valid=01 (addr 0x10), then enq_valid=10 (slot1 addr 0x24).
  - Required: count=2; deq_addr_0=0x10, deq_addr_1=0x24.
- Concurrent enqueue/dequeue with wrap:
  - Stimulus: from count=6, head=6, deq_ready=1 and enq_valid=11 for 4 cycles.
  - Required: count stays 6; tail wraps past 7->0; addresses dequeue strictly in enqueue order.
- Odd drain: count=3, deq_ready=1 for two cycles -> count 1 then 0; deq_valid 11 -> 01 -> 00.
- Flush collision:
  - Stimulus: count=5; flush=1 with enq_valid=11 and deq_ready=1 in the same cycle.
  - Required: next cycle count=0, deq_valid=00, enq_ready=1; rst and flush together also gives count=0.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: decoupling instruction buffer between the 2-wide fetch ROM
// and decode. A circular buffer of DEPTH {address, instruction} entries.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   flush               discard every entry (mispredict / redirect)
//   enq_valid[1:0]      per-slot valid from fetch, bit0 is the older slot
//   enq_addr_0/1        slot addresses
//   enq_inst_0/1        slot instructions
//   enq_ready           room for two entries; fetch holds its PC when low
//   deq_ready           decode consumes every presented valid entry
//   deq_valid[1:0]      bit0 = head valid, bit1 = head+1 valid
//   deq_addr_0/1        head / head+1 addresses (zero when not valid)
//   deq_inst_0/1        head / head+1 instructions (zero when not valid)
//   count               number of occupied entries
module fetch_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [1:0]              enq_valid,
  input  logic [ADDR_WIDTH-1:0]   enq_addr_0,
  input  logic [ADDR_WIDTH-1:0]   enq_addr_1,
  input  logic [DATA_WIDTH-1:0]   enq_inst_0,
  input  logic [DATA_WIDTH-1:0]   enq_inst_1,
  output logic                    enq_ready,
  input  logic                    deq_ready,
  output logic [1:0]              deq_valid,
  output logic [ADDR_WIDTH-1:0]   deq_addr_0,
  output logic [ADDR_WIDTH-1:0]   deq_addr_1,
  output logic [DATA_WIDTH-1:0]   deq_inst_0,
  output logic [DATA_WIDTH-1:0]   deq_inst_1,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic             enq_fire;
  logic [1:0]       n_enq;
  logic [1:0]       n_deq;

  // Ready looks only at the registered count; a same-cycle dequeue is not
  // credited, so fetch always sees a conservative answer.
  assign enq_ready = (count <= CNT_W'(DEPTH - 2));
  assign deq_valid = {(count >= CNT_W'(2)), (count != '0)};

  // DEPTH is a power of two, so the pointers wrap for free.
  assign head_p1 = head + PTR_W'(1);
  assign tail_p1 = tail + PTR_W'(1);

  assign enq_fire = enq_ready & (|enq_valid);
  assign n_enq    = enq_fire  ? (2'(enq_valid[0]) + 2'(enq_valid[1])) : 2'd0;
  assign n_deq    = deq_ready ? (2'(deq_valid[0]) + 2'(deq_valid[1])) : 2'd0;

  // Data is masked to zero for slots that are not valid.
  assign deq_addr_0 = deq_valid[0] ? addr_mem[head]    : '0;
  assign deq_inst_0 = deq_valid[0] ? inst_mem[head]    : '0;
  assign deq_addr_1 = deq_valid[1] ? addr_mem[head_p1] : '0;
  assign deq_inst_1 = deq_valid[1] ? inst_mem[head_p1] : '0;

  // Storage writes: valid slots are compacted, so a lone slot 1 (after a
  // predicted-taken slot 0) lands at tail just like a lone slot 0 would.
  always_ff @(posedge clk) begin
    if (!rst && !flush && enq_fire) begin
      case (enq_valid)
        2'b01: begin
          addr_mem[tail] <= enq_addr_0;
          inst_mem[tail] <= enq_inst_0;
        end
        2'b10: begin
          addr_mem[tail] <= enq_addr_1;
          inst_mem[tail] <= enq_inst_1;
        end
        2'b11: begin
          addr_mem[tail]    <= enq_addr_0;
          inst_mem[tail]    <= enq_inst_0;
          addr_mem[tail_p1] <= enq_addr_1;
          inst_mem[tail_p1] <= enq_inst_1;
        end
        default: ;
      endcase
    end
  end

  // Pointer and occupancy state. Reset wins over flush, and flush discards
  // any enqueue or dequeue happening in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_deq);
      tail  <= tail + PTR_W'(n_enq);
      count <= count + CNT_W'(n_enq) - CNT_W'(n_deq);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven bench for fetch_queue with a scoreboard of
// expected {address, instruction} entries in program order.
module tb_fetch_queue;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [1:0]    enq_valid;
  logic [AW-1:0] enq_addr_0;
  logic [AW-1:0] enq_addr_1;
  logic [DW-1:0] enq_inst_0;
  logic [DW-1:0] enq_inst_1;
  logic          enq_ready;
  logic          deq_ready;
  logic [1:0]    deq_valid;
  logic [AW-1:0] deq_addr_0;
  logic [AW-1:0] deq_addr_1;
  logic [DW-1:0] deq_inst_0;
  logic [DW-1:0] deq_inst_1;
  logic [$clog2(DEPTH):0] count;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] inst;
  } entry_t;

  typedef struct {
    logic       flush;
    logic [1:0] ev;
    logic       dr;
    int         exp_cnt;
    logic [1:0] exp_dv;
  } vec_t;

  entry_t  sb[$];
  vec_t    vecs[28];
  int      checks;
  int      failures;
  logic [AW-1:0] next_addr;

  fetch_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid),
    .enq_addr_0(enq_addr_0), .enq_addr_1(enq_addr_1),
    .enq_inst_0(enq_inst_0), .enq_inst_1(enq_inst_1),
    .enq_ready(enq_ready), .deq_ready(deq_ready), .deq_valid(deq_valid),
    .deq_addr_0(deq_addr_0), .deq_addr_1(deq_addr_1),
    .deq_inst_0(deq_inst_0), .deq_inst_1(deq_inst_1),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] inst_of(input logic [AW-1:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic compare(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus. Inputs change at the falling edge; the scoreboard
  // pops and compares whatever decode consumes, pushes whatever fetch gets
  // in, then inputs return to idle just after the rising edge.
  task automatic applyStimulus(input logic r, input logic f,
                               input logic [1:0] ev, input logic dr,
                               input logic [AW-1:0] a0,
                               input logic [AW-1:0] a1);
    entry_t e;
    logic   m_ready;
    @(negedge clk);
    rst = r; flush = f; enq_valid = ev; deq_ready = dr;
    enq_addr_0 = a0; enq_inst_0 = inst_of(a0);
    enq_addr_1 = a1; enq_inst_1 = inst_of(a1);
    #1;
    if (r || f) begin
      sb.delete();
    end else begin
      m_ready = ((DEPTH - sb.size()) >= 2);
      if (dr && sb.size() >= 1) begin
        e = sb.pop_front();
        compare("pop_addr_0", 64'(deq_addr_0), 64'(e.addr));
        compare("pop_inst_0", 64'(deq_inst_0), 64'(e.inst));
        if (sb.size() >= 1) begin
          e = sb.pop_front();
          compare("pop_addr_1", 64'(deq_addr_1), 64'(e.addr));
          compare("pop_inst_1", 64'(deq_inst_1), 64'(e.inst));
        end
      end
      if (m_ready) begin
        if (ev[0]) sb.push_back('{addr: a0, inst: inst_of(a0)});
        if (ev[1]) sb.push_back('{addr: a1, inst: inst_of(a1)});
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0; flush = 1'b0; enq_valid = 2'b00; deq_ready = 1'b0;
  endtask

  // Compares every output against the scoreboard's view of the queue.
  task automatic checkOutput();
    int n;
    n = sb.size();
    compare("count", 64'(count), 64'(n));
    compare("count_le_depth", 64'(count <= DEPTH), 64'(1));
    compare("deq_valid", 64'(deq_valid), 64'({(n >= 2), (n >= 1)}));
    compare("enq_ready", 64'(enq_ready), 64'((DEPTH - n) >= 2));
    compare("peek_addr_0", 64'(deq_addr_0), (n >= 1) ? 64'(sb[0].addr) : 64'(0));
    compare("peek_inst_0", 64'(deq_inst_0), (n >= 1) ? 64'(sb[0].inst) : 64'(0));
    compare("peek_addr_1", 64'(deq_addr_1), (n >= 2) ? 64'(sb[1].addr) : 64'(0));
    compare("peek_inst_1", 64'(deq_inst_1), (n >= 2) ? 64'(sb[1].inst) : 64'(0));
  endtask

  initial begin
    checks = 0; failures = 0; next_addr = '0;
    rst = 1'b0; flush = 1'b0; enq_valid = 2'b00; deq_ready = 1'b0;
    enq_addr_0 = '0; enq_addr_1 = '0; enq_inst_0 = '0; enq_inst_1 = '0;

    // flush, enq_valid, deq_ready, expected count, expected deq_valid
    vecs[0]  = '{1'b0, 2'b11, 1'b0, 2, 2'b11};
    vecs[1]  = '{1'b0, 2'b11, 1'b0, 4, 2'b11};
    vecs[2]  = '{1'b0, 2'b11, 1'b0, 6, 2'b11};
    vecs[3]  = '{1'b0, 2'b11, 1'b0, 8, 2'b11};
    vecs[4]  = '{1'b0, 2'b11, 1'b0, 8, 2'b11};
    vecs[5]  = '{1'b0, 2'b00, 1'b1, 6, 2'b11};
    vecs[6]  = '{1'b0, 2'b00, 1'b1, 4, 2'b11};
    vecs[7]  = '{1'b0, 2'b00, 1'b1, 2, 2'b11};
    vecs[8]  = '{1'b0, 2'b11, 1'b0, 4, 2'b11};
    vecs[9]  = '{1'b0, 2'b11, 1'b0, 6, 2'b11};
    vecs[10] = '{1'b0, 2'b11, 1'b1, 6, 2'b11};
    vecs[11] = '{1'b0, 2'b11, 1'b1, 6, 2'b11};
    vecs[12] = '{1'b0, 2'b11, 1'b1, 6, 2'b11};
    vecs[13] = '{1'b0, 2'b11, 1'b1, 6, 2'b11};
    vecs[14] = '{1'b0, 2'b00, 1'b1, 4, 2'b11};
    vecs[15] = '{1'b0, 2'b01, 1'b1, 3, 2'b11};
    vecs[16] = '{1'b0, 2'b00, 1'b1, 1, 2'b01};
    vecs[17] = '{1'b0, 2'b00, 1'b1, 0, 2'b00};
    vecs[18] = '{1'b0, 2'b00, 1'b1, 0, 2'b00};
    vecs[19] = '{1'b0, 2'b11, 1'b0, 2, 2'b11};
    vecs[20] = '{1'b0, 2'b11, 1'b0, 4, 2'b11};
    vecs[21] = '{1'b0, 2'b11, 1'b0, 6, 2'b11};
    vecs[22] = '{1'b0, 2'b01, 1'b0, 7, 2'b11};
    vecs[23] = '{1'b0, 2'b11, 1'b1, 5, 2'b11};
    vecs[24] = '{1'b0, 2'b10, 1'b0, 6, 2'b11};
    vecs[25] = '{1'b0, 2'b01, 1'b1, 5, 2'b11};
    vecs[26] = '{1'b1, 2'b11, 1'b1, 0, 2'b00};
    vecs[27] = '{1'b0, 2'b00, 1'b0, 0, 2'b00};

    // Reset then idle.
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, '0, '0);
    checkOutput();
    compare("rst_count", 64'(count), 64'(0));
    compare("rst_deq_valid", 64'(deq_valid), 64'(0));
    compare("rst_enq_ready", 64'(enq_ready), 64'(1));

    for (int i = 0; i < 28; i++) begin
      applyStimulus(1'b0, vecs[i].flush, vecs[i].ev, vecs[i].dr,
                    next_addr, next_addr + 32'h4);
      next_addr = next_addr + 32'h8;
      checkOutput();
      compare($sformatf("row%0d_count", i), 64'(count), 64'(vecs[i].exp_cnt));
      compare($sformatf("row%0d_deq_valid", i), 64'(deq_valid), 64'(vecs[i].exp_dv));
      if (i == 4) begin
        compare("full_enq_ready", 64'(enq_ready), 64'(0));
        compare("full_head_addr_0", 64'(deq_addr_0), 64'(32'h0));
        compare("full_head_addr_1", 64'(deq_addr_1), 64'(32'h4));
      end
    end

    // Predict-taken slot 0 alone, then a lone slot 1 compacted behind it.
    applyStimulus(1'b0, 1'b0, 2'b01, 1'b0, 32'h10, 32'h14);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h24);
    checkOutput();
    compare("compact_count", 64'(count), 64'(2));
    compare("compact_addr_0", 64'(deq_addr_0), 64'(32'h10));
    compare("compact_addr_1", 64'(deq_addr_1), 64'(32'h24));

    // Reset and flush together with enqueue and dequeue pending.
    applyStimulus(1'b1, 1'b1, 2'b11, 1'b1, 32'h40, 32'h44);
    checkOutput();
    compare("rst_flush_count", 64'(count), 64'(0));
    compare("rst_flush_enq_ready", 64'(enq_ready), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
